stopwatch_bcd: RTL and testbench

Counts 1-cycle `tick` pulses from the upstream `prog_timer` (its `zero` output; a 24'd5000000 terminal count gives 10 Hz at 50 MHz) and keeps elapsed time as four BCD digits, M:SS.t. A start/stop button toggles counting and a clear input zeroes the count. The digits feed the seven-segment display driver downstream.

---
 rtl/stopwatch_bcd.sv | 103 ++++++++++
 tb/tb_stopwatch_bcd.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - M:SS.t BCD stopwatch counting prescaled tick pulses
// Start/stop toggles RUN/PAUSE on a rising edge; clear and reset return to a zeroed IDLE.
module stopwatch_bcd #(
   parameter int TICKS_PER_COUNT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       clear,
   output logic       running,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_COUNT - 1);

   state_t     state;
   state_t     state_next;
   logic       ss_prev;
   logic       press;
   logic       inc;
   logic [7:0] pre;

   assign press   = start_stop & ~ss_prev;
   assign inc     = (state == RUN) && tick && (pre == PRE_LAST);
   assign running = (state == RUN);

   // ss_prev resets high so a button held through reset release is not a press
   always_ff @(posedge clk) begin
      if (reset)
         ss_prev <= 1'b1;
      else
         ss_prev <= start_stop;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = IDLE;
      end else if (press) begin
         case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = PAUSE;
            PAUSE:   state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear || state == IDLE)
         pre <= 8'd0;
      else if (state == RUN && tick)
         pre <= (pre == PRE_LAST) ? 8'd0 : pre + 8'd1;
   end

   // Ripple-carry BCD chain; a carry out of minutes wraps to 0:00.0 and latches overflow
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         d0       <= 4'd0;
         d1       <= 4'd0;
         d2       <= 4'd0;
         d3       <= 4'd0;
         overflow <= 1'b0;
      end else if (inc) begin
         if (d0 != 4'd9) begin
            d0 <= d0 + 4'd1;
         end else begin
            d0 <= 4'd0;
            if (d1 != 4'd9) begin
               d1 <= d1 + 4'd1;
            end else begin
               d1 <= 4'd0;
               if (d2 != 4'd5) begin
                  d2 <= d2 + 4'd1;
               end else begin
                  d2 <= 4'd0;
                  if (d3 != 4'd9) begin
                     d3 <= d3 + 4'd1;
                  end else begin
                     d3       <= 4'd0;
                     overflow <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - randomized and directed bench for stopwatch_bcd
// Two instances (1 and 3 ticks per count) share stimulus and are checked against an elapsed-tenths model.
module tb_stopwatch_bcd;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tick = 1'b0;
   logic start_stop = 1'b0;
   logic clear = 1'b0;

   logic       running_a, overflow_a, running_b, overflow_b;
   logic [3:0] d0_a, d1_a, d2_a, d3_a, d0_b, d1_b, d2_b, d3_b;

   always #5 clk = ~clk;

   stopwatch_bcd #(.TICKS_PER_COUNT(1)) dut_a (
      .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
      .running(running_a), .d0(d0_a), .d1(d1_a), .d2(d2_a), .d3(d3_a), .overflow(overflow_a)
   );

   stopwatch_bcd #(.TICKS_PER_COUNT(3)) dut_b (
      .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
      .running(running_b), .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b), .overflow(overflow_b)
   );

   logic [17:0] dv [2];
   assign dv[0] = {running_a, overflow_a, d3_a, d2_a, d1_a, d0_a};
   assign dv[1] = {running_b, overflow_b, d3_b, d2_b, d1_b, d0_b};

   // Model: mode 0 stopped/zeroed, 1 counting, 2 holding; elapsed time kept as plain tenths
   int m_mode [2];
   int m_tenths [2];
   int m_phase [2];
   bit m_ovf [2];
   int ratio [2] = '{1, 3};
   bit m_btn_prev;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   function automatic logic [17:0] pack(bit run, bit ovf, int t);
      logic [3:0] m, st, su, te;
      m  = 4'(t / 600);
      st = 4'((t / 100) % 6);
      su = 4'((t / 10) % 10);
      te = 4'(t % 10);
      return {run, ovf, m, st, su, te};
   endfunction

   function automatic logic [17:0] model_vec(int k);
      return pack(m_mode[k] == 1, m_ovf[k], m_tenths[k]);
   endfunction

   always @(posedge clk) begin
      bit pressed;
      pressed = start_stop && !m_btn_prev;
      for (int k = 0; k < 2; k++) begin
         if (reset || clear) begin
            m_mode[k] = 0; m_tenths[k] = 0; m_phase[k] = 0; m_ovf[k] = 0;
         end else begin
            if (m_mode[k] == 1 && tick) begin
               m_phase[k] = m_phase[k] + 1;
               if (m_phase[k] == ratio[k]) begin
                  m_phase[k] = 0;
                  if (m_tenths[k] == 5999) begin
                     m_tenths[k] = 0;
                     m_ovf[k] = 1;
                  end else begin
                     m_tenths[k] = m_tenths[k] + 1;
                  end
               end
            end
            if (pressed)
               m_mode[k] = (m_mode[k] == 1) ? 2 : 1;
         end
      end
      m_btn_prev = reset ? 1'b1 : start_stop;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            n_total++;
            if (dv[k] === model_vec(k))
               n_pass++;
            else
               $display("FAIL model_cmp inst%0d t=%0t actual=%h required=%h", k, $time, dv[k], model_vec(k));
         end
      end
   end

   task automatic step(input logic t, input logic s, input logic c);
      tick = t; start_stop = s; clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
      tick = 1'b0;
   endtask

   task automatic press_btn();
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_lit(input string name, input int k, input logic [17:0] exp);
      n_total++;
      if (dv[k] === exp)
         n_pass++;
      else
         $display("FAIL %s inst%0d actual=%h required=%h", name, k, dv[k], exp);
   endtask

   initial begin
      m_btn_prev = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_tenths[k] = 0; m_phase[k] = 0; m_ovf[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk_lit("reset_state", 0, 18'h0);
      reset = 1'b0;

      ticks(20);
      chk_lit("idle_ticks", 0, 18'h0);

      press_btn();
      ticks(125);
      chk_lit("run_12_5", 0, {1'b1, 1'b0, 4'd0, 4'd1, 4'd2, 4'd5});
      press_btn();
      ticks(10);
      chk_lit("pause_hold", 0, {1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd5});
      press_btn();
      ticks(1);
      chk_lit("resume_12_6", 0, {1'b1, 1'b0, 4'd0, 4'd1, 4'd2, 4'd6});

      step(1'b0, 1'b0, 1'b1);
      press_btn();
      ticks(599);
      chk_lit("carry_59_9", 0, {1'b1, 1'b0, 4'd0, 4'd5, 4'd9, 4'd9});
      ticks(1);
      chk_lit("carry_1_00", 0, {1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0});

      step(1'b0, 1'b0, 1'b1);
      press_btn();
      ticks(5999);
      chk_lit("max_9_59_9", 0, {1'b1, 1'b0, 4'd9, 4'd5, 4'd9, 4'd9});
      ticks(1);
      chk_lit("wrap_overflow", 0, {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0});

      step(1'b1, 1'b0, 1'b1);
      chk_lit("tick_clear", 0, 18'h0);

      press_btn();
      ticks(7);
      chk_lit("presc_0_2", 1, {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd2});
      press_btn();
      press_btn();
      ticks(2);
      chk_lit("presc_phase_0_3", 1, {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd3});

      step(1'b0, 1'b0, 1'b1);
      press_btn();
      ticks(4);
      step(1'b1, 1'b1, 1'b0);
      chk_lit("tick_press_run", 0, {1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5});
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk_lit("tick_press_pause", 0, {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5});
      step(1'b0, 1'b0, 1'b0);

      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk_lit("held_button", 0, {1'b1, 1'b0, 16'h0});

      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk_lit("press_during_clear", 0, 18'h0);
      step(1'b0, 1'b0, 1'b0);

      start_stop = 1'b1;
      reset = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      chk_lit("held_through_reset", 0, 18'h0);
      step(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 499) == 0);
         step(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 99) == 0));
      end
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
